regfile_writeback_unit: RTL and testbench

- Writer side of the operand register file: the single point that drives its write port (regWrEnSc, regWrEnVec, regToWrite, dataIn).
- Accepts full-vector results from the execute stage and element-serial load data from the memory stage.
- Assembles load elements into vectors and queues completed writes in a small FIFO.
- Issues at most one register-file write per cycle, in commit order.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_fifo.sv | 55 +++++
 rtl/regfile_writeback_unit.sv | 133 +++++++++++++
 tb/tb_regfile_writeback_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and sizes for the register-file writeback unit
package wb_pkg;

  localparam int REGISTER_SIZE  = 16;
  localparam int VECTOR_SIZE    = 4;
  localparam int SELECTION_BITS = 3;
  localparam int FIFO_DEPTH     = 2;
  localparam int SCALAR_BIT     = SELECTION_BITS - 2;
  localparam int LANE_W         = $clog2(VECTOR_SIZE);

  typedef struct packed {
    logic [SELECTION_BITS-1:0]                  dest;
    logic [VECTOR_SIZE-1:0][REGISTER_SIZE-1:0]  data;
    logic                                       is_scalar;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    COMMIT
  } wb_state_t;

  function automatic logic is_scalar_dest(input logic [SELECTION_BITS-1:0] dest);
    return dest[SCALAR_BIT];
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small synchronous FIFO of pending register-file writes
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  input  logic      pop_i,
  output wb_entry_t pop_data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/regfile_writeback_unit.sv
// rtl/regfile_writeback_unit.sv - load assembler, ALU arbitration and registered register-file write port
module regfile_writeback_unit
  import wb_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   aluValid,
  output logic                                   aluReady,
  input  logic [SELECTION_BITS-1:0]              aluDest,
  input  logic [VECTOR_SIZE*REGISTER_SIZE-1:0]   aluData,
  input  logic                                   memValid,
  output logic                                   memReady,
  input  logic [SELECTION_BITS-1:0]              memDest,
  input  logic [REGISTER_SIZE-1:0]               memElem,
  input  logic                                   memLast,
  output logic                                   regWrEnSc,
  output logic                                   regWrEnVec,
  output logic [SELECTION_BITS-1:0]              regToWrite,
  output logic [VECTOR_SIZE*REGISTER_SIZE-1:0]   dataIn,
  output logic                                   busy
);

  localparam int CNT_W = LANE_W + 1;

  wb_state_t                                 state_q, state_d;
  logic [CNT_W-1:0]                          cnt_q, cnt_d;
  logic [SELECTION_BITS-1:0]                 dest_q, dest_d;
  logic [VECTOR_SIZE-1:0][REGISTER_SIZE-1:0] lanes_q, lanes_d;
  logic                                      asm_push;

  logic                                      wr_sc_q, wr_vec_q;
  logic [SELECTION_BITS-1:0]                 wr_addr_q;
  logic [VECTOR_SIZE-1:0][REGISTER_SIZE-1:0] wr_data_q;

  wb_entry_t fifo_in, fifo_out, asm_entry, alu_entry;
  logic      fifo_push, fifo_full, fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dest_q  <= '0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      lanes_q <= lanes_d;
    end
  end

  // Lanes beyond an early memLast stay zero because the buffer is cleared on every commit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dest_d   = dest_q;
    lanes_d  = lanes_q;
    asm_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (memValid) begin
          dest_d     = memDest;
          lanes_d    = '0;
          lanes_d[0] = memElem;
          cnt_d      = CNT_W'(1);
          state_d    = (is_scalar_dest(memDest) || memLast) ? COMMIT : COLLECT;
        end
      end
      COLLECT: begin
        if (memValid) begin
          lanes_d[cnt_q[LANE_W-1:0]] = memElem;
          cnt_d = cnt_q + 1'b1;
          if (memLast || cnt_q == CNT_W'(VECTOR_SIZE - 1)) state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (!fifo_full) begin
          asm_push = 1'b1;
          lanes_d  = '0;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign memReady  = (state_q != COMMIT);
  assign aluReady  = !fifo_full && (state_q != COMMIT);

  assign asm_entry = '{dest: dest_q, data: lanes_q, is_scalar: is_scalar_dest(dest_q)};
  assign alu_entry = '{dest: aluDest, data: aluData, is_scalar: is_scalar_dest(aluDest)};
  assign fifo_push = asm_push || (aluValid && aluReady);
  assign fifo_in   = asm_push ? asm_entry : alu_entry;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (fifo_push),
    .push_data_i (fifo_in),
    .pop_i       (!fifo_empty),
    .pop_data_o  (fifo_out),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // The head is drained every cycle it exists; idle cycles force the port to all zeros.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_sc_q   <= 1'b0;
      wr_vec_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (!fifo_empty) begin
      wr_sc_q   <= fifo_out.is_scalar;
      wr_vec_q  <= !fifo_out.is_scalar;
      wr_addr_q <= fifo_out.dest;
      wr_data_q <= fifo_out.data;
    end else begin
      wr_sc_q   <= 1'b0;
      wr_vec_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end
  end

  assign regWrEnSc  = wr_sc_q;
  assign regWrEnVec = wr_vec_q;
  assign regToWrite = wr_addr_q;
  assign dataIn     = wr_data_q;
  assign busy       = (state_q != IDLE) || !fifo_empty || wr_sc_q || wr_vec_q;

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// tb/tb_regfile_writeback_unit.sv - scoreboard bench for the register-file writeback unit
module tb_regfile_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        aluValid, aluReady;
  logic [2:0]  aluDest;
  logic [63:0] aluData;
  logic        memValid, memReady;
  logic [2:0]  memDest;
  logic [15:0] memElem;
  logic        memLast;
  logic        regWrEnSc, regWrEnVec;
  logic [2:0]  regToWrite;
  logic [63:0] dataIn;
  logic        busy;

  typedef struct {
    logic        sc;
    logic        vec;
    logic [2:0]  addr;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  regfile_writeback_unit dut (
    .clk        (clk),
    .reset      (reset),
    .aluValid   (aluValid),
    .aluReady   (aluReady),
    .aluDest    (aluDest),
    .aluData    (aluData),
    .memValid   (memValid),
    .memReady   (memReady),
    .memDest    (memDest),
    .memElem    (memElem),
    .memLast    (memLast),
    .regWrEnSc  (regWrEnSc),
    .regWrEnVec (regWrEnVec),
    .regToWrite (regToWrite),
    .dataIn     (dataIn),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe pops one expected entry.
  always @(negedge clk) begin
    if (reset && (regWrEnSc || regWrEnVec)) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write sc=%0b vec=%0b addr=%0d data=%0h", regWrEnSc, regWrEnVec, regToWrite, dataIn);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (regWrEnSc !== e.sc || regWrEnVec !== e.vec || regToWrite !== e.addr || dataIn !== e.data) begin
          fails++;
          $display("FAIL write_data actual sc=%0b vec=%0b addr=%0d data=%0h expected sc=%0b vec=%0b addr=%0d data=%0h",
                   regWrEnSc, regWrEnVec, regToWrite, dataIn, e.sc, e.vec, e.addr, e.data);
        end
      end
    end
  end

  task automatic expect_write(input logic sc, input logic [2:0] addr, input logic [63:0] data);
    exp_t e;
    e.sc = sc; e.vec = !sc; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic alu_send(input logic [2:0] d, input logic [63:0] data, input logic sc, output int waits);
    aluValid = 1'b1; aluDest = d; aluData = data; waits = 0;
    @(negedge clk);
    while (!aluReady && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!aluReady) begin
      tests++; fails++;
      $display("FAIL alu_handshake_timeout actual=aluReady_low expected=aluReady_high");
    end else begin
      expect_write(sc, d, data);
    end
    @(posedge clk); #1;
    aluValid = 1'b0;
  endtask

  task automatic mem_beat(input logic [2:0] d, input logic [15:0] elem, input logic last);
    int waits;
    memValid = 1'b1; memDest = d; memElem = elem; memLast = last; waits = 0;
    @(negedge clk);
    while (!memReady && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!memReady) begin
      tests++; fails++;
      $display("FAIL mem_handshake_timeout actual=memReady_low expected=memReady_high");
    end
    @(posedge clk); #1;
    memValid = 1'b0; memLast = 1'b0;
  endtask

  initial begin
    int w;
    reset = 1'b0; aluValid = 1'b0; aluDest = '0; aluData = '0;
    memValid = 1'b0; memDest = '0; memElem = '0; memLast = 1'b0;
    #3;
    check("rst_wr_sc", regWrEnSc, 0);
    check("rst_wr_vec", regWrEnVec, 0);
    check("rst_addr", regToWrite, 0);
    check("rst_data", dataIn, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_ready", memReady, 1);
    check("rst_alu_ready", aluReady, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // ALU vector write with latency check
    alu_send(3'b001, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, w);
    @(negedge clk); check("alu_lat_cycle1_vec", regWrEnVec, 0);
    @(negedge clk); check("alu_lat_cycle2_vec", regWrEnVec, 1);
    check("alu_lat_cycle2_sc", regWrEnSc, 0);
    @(negedge clk); check("alu_one_cycle_vec", regWrEnVec, 0);
    repeat (2) @(posedge clk); #1;

    // scalar load
    mem_beat(3'b010, 16'h00AB, 1'b1);
    expect_write(1'b1, 3'b010, 64'h00AB);
    @(negedge clk); check("scalar_load_commit", memReady, 0);
    repeat (4) @(posedge clk); #1;

    // four-beat vector load
    mem_beat(3'b000, 16'd10, 1'b0);
    mem_beat(3'b000, 16'd20, 1'b0);
    mem_beat(3'b000, 16'd30, 1'b0);
    mem_beat(3'b000, 16'd40, 1'b1);
    expect_write(1'b0, 3'b000, {16'd40, 16'd30, 16'd20, 16'd10});
    @(negedge clk); check("vec_load_commit_ready", memReady, 0);
    @(negedge clk); check("vec_load_after_commit_ready", memReady, 1);
    repeat (4) @(posedge clk); #1;

    // early memLast on beat 2 to vector dest 5
    mem_beat(3'b101, 16'd5, 1'b0);
    mem_beat(3'b101, 16'd6, 1'b1);
    expect_write(1'b0, 3'b101, {16'd0, 16'd0, 16'd6, 16'd5});
    repeat (4) @(posedge clk); #1;

    // assembler commit coincides with an ALU result
    mem_beat(3'b110, 16'h1234, 1'b1);
    expect_write(1'b1, 3'b110, 64'h1234);
    aluValid = 1'b1; aluDest = 3'b101; aluData = 64'h0102_0304_0506_0708;
    @(negedge clk); check("coincide_alu_ready", aluReady, 0);
    alu_send(3'b101, 64'h0102_0304_0506_0708, 1'b0, w);
    check("coincide_alu_waits", w, 0);
    repeat (4) @(posedge clk); #1;

    // sustained back-to-back ALU writes, including an ALU scalar
    alu_send(3'b111, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, w);
    check("burst0_waits", w, 0);
    alu_send(3'b100, 64'h1111_2222_3333_4444, 1'b0, w);
    check("burst1_waits", w, 0);
    alu_send(3'b010, 64'h0000_0000_0000_5555, 1'b1, w);
    check("burst2_waits", w, 0);
    repeat (4) @(posedge clk); #1;

    // reset in the middle of a vector load
    mem_beat(3'b000, 16'h1111, 1'b0);
    mem_beat(3'b000, 16'h2222, 1'b0);
    #2 reset = 1'b0;
    #1 check("midload_rst_busy", busy, 0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("after_rst_busy", busy, 0);
    check("after_rst_mem_ready", memReady, 1);
    @(posedge clk); #1;
    mem_beat(3'b001, 16'd7, 1'b0);
    mem_beat(3'b001, 16'd8, 1'b1);
    expect_write(1'b0, 3'b001, {16'd0, 16'd0, 16'd8, 16'd7});

    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("final_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
